// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: request kinds, MIPS opcode/funct
// values, FSM state codes and word-packing helpers.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        K_ADD  = 4'd0,
        K_SUB  = 4'd1,
        K_AND  = 4'd2,
        K_OR   = 4'd3,
        K_SLT  = 4'd4,
        K_LW   = 4'd5,
        K_SW   = 4'd6,
        K_BEQ  = 4'd7,
        K_ADDI = 4'd8,
        K_LUI  = 4'd9,
        K_ORI  = 4'd10,
        K_J    = 4'd11
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ST_LOAD = 2'd0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
    localparam logic [1:0] ST_PAD  = 2'd1;
`endif
    localparam logic [1:0] ST_FULL = 2'd2;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-memory write bus for the instruction encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: symbolic request fields -> 32-bit MIPS word plus a legal flag.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (kind)
            K_ADD:   word = r_word(rs, rt, rd, FN_ADD);
            K_SUB:   word = r_word(rs, rt, rd, FN_SUB);
            K_AND:   word = r_word(rs, rt, rd, FN_AND);
            K_OR:    word = r_word(rs, rt, rd, FN_OR);
            K_SLT:   word = r_word(rs, rt, rd, FN_SLT);
            K_LW:    word = i_word(OP_LW, rs, rt, imm);
            K_SW:    word = i_word(OP_SW, rs, rt, imm);
            K_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
            K_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
            K_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
            K_ORI:   word = i_word(OP_ORI, rs, rt, imm);
            K_J:     word = {OP_J, target};
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts symbolic requests and streams packed words into imem.
// Optional NOP padding to the end of memory on seal: INSTR_ENCODER_NOP_PAD_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            seal,
    instr_encoder_if.slave  bus,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            err
);
    localparam int unsigned     DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    logic [1:0]        state;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word;
    logic              legal;
    logic              accept;
    logic              last;

    instr_pack u_pack (
        .kind   (bus.in_kind),
        .rs     (bus.in_rs),
        .rt     (bus.in_rt),
        .rd     (bus.in_rd),
        .imm    (bus.in_imm),
        .target (bus.in_target),
        .word   (word),
        .legal  (legal)
    );

    assign bus.in_ready = (state == ST_LOAD) && !full && !clear;
    assign accept       = bus.in_valid && bus.in_ready;
    // The write in progress is the final one when count is one short of DEPTH.
    assign last         = (count == LAST_CNT);
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;

`ifdef INSTR_ENCODER_NOP_PAD_EN
    logic seal_go;
    assign seal_go = seal && (state == ST_LOAD) && !full;
`else
    logic seal_unused;
    assign seal_unused = seal;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state   <= ST_LOAD;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            count   <= '0;
            full    <= 1'b0;
            err     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (legal) begin
                            we_q    <= 1'b1;
                            waddr_q <= count[ADDR_W-1:0];
                            wdata_q <= word;
                            count   <= count + 1'b1;
                            if (last) begin
                                full  <= 1'b1;
                                state <= ST_FULL;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
`ifdef INSTR_ENCODER_NOP_PAD_EN
                    // A coincident request is written first; padding resumes after it.
                    if (seal_go && !(accept && legal && last))
                        state <= ST_PAD;
`endif
                end
`ifdef INSTR_ENCODER_NOP_PAD_EN
                ST_PAD: begin
                    we_q    <= 1'b1;
                    waddr_q <= count[ADDR_W-1:0];
                    wdata_q <= '0;
                    count   <= count + 1'b1;
                    if (last) begin
                        full  <= 1'b1;
                        state <= ST_FULL;
                    end
                end
`endif
                ST_FULL: begin
                    state <= ST_FULL;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;
    localparam int ADDR_W = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic            seal;
    logic [ADDR_W:0] count;
    logic            full;
    logic            err;
    int              total = 0;
    int              bad   = 0;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .seal  (seal),
        .bus   (bus),
        .count (count),
        .full  (full),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        bus.in_valid  = 1'b1;
        bus.in_kind   = kind;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        tick();
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] cnt);
        chk({tag, "_we"}, bus.we, 1);
        chk({tag, "_addr"}, bus.waddr, addr);
        chk({tag, "_data"}, bus.wdata, data);
        chk({tag, "_count"}, count, cnt);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; seal = 1'b0;
        bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_rs = '0; bus.in_rt = '0;
        bus.in_rd = '0; bus.in_imm = '0; bus.in_target = '0;
        tick(); tick();
        chk("rst_we", bus.we, 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", bus.in_ready, 1);

        req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);          // ADD $3,$1,$2
        chk_wr("add", 0, 32'h0022_1820, 1);

        req(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);      // LW $8,4($29)
        chk_wr("lw", 1, 32'h8FA8_0004, 2);
        req(4'd9, 5'd7, 5'd1, 5'd0, 16'h1234, 26'h0);       // LUI $1 (rs ignored)
        chk_wr("lui", 2, 32'h3C01_1234, 3);
        req(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);       // BEQ $1,$2,-1
        chk_wr("beq", 3, 32'h1022_FFFF, 4);
        req(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);        // J 0x10
        chk_wr("j", 4, 32'h0800_0010, 5);

        req(4'd13, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);         // illegal kind
        chk("ill_we", bus.we, 0);
        chk("ill_count", count, 5);
        chk("ill_err", err, 1);
        req(4'd0, 5'd5, 5'd6, 5'd4, 16'h0, 26'h0);          // ADD $4,$5,$6
        chk_wr("add2", 5, 32'h00A6_2020, 6);
        chk("err_held", err, 1);

        for (int i = 6; i < 63; i++) req(4'd10, 5'd1, 5'd1, 5'd0, 16'(i), 26'h0);
        chk("fill_count", count, 63);
        chk("fill_notfull", full, 0);
        req(4'd10, 5'd1, 5'd1, 5'd0, 16'hBEEF, 26'h0);      // ORI $1,$1,0xBEEF
        chk_wr("last", 63, 32'h3421_BEEF, 64);
        chk("full_set", full, 1);
        chk("full_ready", bus.in_ready, 0);
        tick();
        chk("full_no_we", bus.we, 0);
        chk("full_count", count, 64);

        clear = 1'b1;
        #1;
        chk("clr_ready", bus.in_ready, 0);
        tick();
        clear = 1'b0;
        chk("clr_we", bus.we, 0);
        chk("clr_count", count, 0);
        chk("clr_full", full, 0);
        chk("clr_err", err, 0);
        req(4'd1, 5'd8, 5'd9, 5'd7, 16'h0, 26'h0);          // SUB $7,$8,$9
        chk_wr("sub", 0, 32'h0109_3822, 1);

        bus.in_kind = 4'd2;
        clear = 1'b1;
        #1;
        chk("clrv_ready", bus.in_ready, 0);
        tick();
        clear = 1'b0;
        chk("clrv_we", bus.we, 0);
        chk("clrv_count", count, 0);

        req(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        req(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        chk("pre_rst_count", count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_we", bus.we, 0);
        chk("mid_rst_waddr", bus.waddr, 0);
        chk("mid_rst_wdata", bus.wdata, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_full", full, 0);

        req(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);          // SLT $3,$1,$2
        chk_wr("slt", 0, 32'h0022_182A, 1);
        req(4'd8, 5'd2, 5'd5, 5'd0, 16'h8000, 26'h0);       // ADDI $5,$2,0x8000
        chk_wr("addi", 1, 32'h2045_8000, 2);
        req(4'd6, 5'd4, 5'd3, 5'd0, 16'h0008, 26'h0);       // SW $3,8($4)
        chk_wr("sw", 2, 32'hAC83_0008, 3);
        bus.in_valid = 1'b0;
        seal = 1'b1;
        tick();
        seal = 1'b0;
        chk("seal_we", bus.we, 0);
`ifdef INSTR_ENCODER_NOP_PAD_EN
        chk("pad_ready", bus.in_ready, 0);
        for (int a = 3; a < 64; a++) begin
            tick();
            chk_wr("pad", 32'(a), 32'h0, 32'(a + 1));
        end
        chk("pad_full", full, 1);
        tick();
        chk("pad_done_we", bus.we, 0);
`else
        tick();
        chk("noseal_we", bus.we, 0);
        chk("noseal_count", count, 3);
        chk("noseal_ready", bus.in_ready, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
